// File: rtl/zcu_dtmf_pkg.sv
// Shared definitions for the DTMF code-entry controller and the elapsed-time counter.
// Holds key encodings, the controller state type, the millisecond type and digit-lookup helpers.
package zcu_dtmf_pkg;

    localparam logic [3:0] DTMF_STAR  = 4'hA;
    localparam logic [3:0] DTMF_POUND = 4'hB;
    localparam logic [3:0] DTMF_A     = 4'hC;
    localparam logic [3:0] DTMF_B     = 4'hD;
    localparam logic [3:0] DTMF_C     = 4'hE;
    localparam logic [3:0] DTMF_D     = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_e;

    typedef logic [23:0] ms_t;

    function automatic logic is_numeric(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    // Digit idx of a BCD-packed code, digit 0 being the first one entered.
    function automatic logic [3:0] code_digit(input logic [31:0] code, input logic [2:0] idx);
        logic [31:0] shifted;
        shifted = code >> {idx, 2'b00};
        return shifted[3:0];
    endfunction

endpackage

// File: rtl/zcu_dtmf_code_entry.sv
// Collects DTMF digits, checks them against an access code and drives the elapsed-time
// counter's clear level and start toggle; reports the outcome as one-cycle ok/bad pulses.
module zcu_dtmf_code_entry
    import zcu_dtmf_pkg::*;
#(
    parameter int          CODE_LEN   = 4,
    parameter logic [31:0] CODE       = 32'h0000_7331,
    parameter ms_t         TIMEOUT_MS = 24'd5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  ms_t        elapsed,
    output logic       timer_clear,
    output logic       timer_start,
    output logic       busy,
    output logic [3:0] digit_count,
    output logic       code_ok,
    output logic       code_bad
);

    localparam logic [3:0] CODE_LEN_C = 4'(CODE_LEN);

    state_e     state_q, state_d;
    logic [3:0] count_q, count_d;
    logic       mismatch_q, mismatch_d;
    logic       clear_q, clear_d;
    logic       start_q, start_d;
    logic       ok_q, ok_d;
    logic       bad_q, bad_d;

    logic       isStar;
    logic       isPound;
    logic       isNum;
    logic       timedOut;
    logic       fullMatch;

    assign isStar    = digit_valid && (digit == DTMF_STAR);
    assign isPound   = digit_valid && (digit == DTMF_POUND);
    assign isNum     = digit_valid && is_numeric(digit);
    assign timedOut  = (elapsed >= TIMEOUT_MS);
    assign fullMatch = (count_q == CODE_LEN_C) && !mismatch_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        clear_d    = clear_q;
        start_d    = start_q;
        ok_d       = 1'b0;
        bad_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clear_d = 1'b1;
                if (isNum) begin
                    mismatch_d = (digit != code_digit(CODE, 3'd0));
                    count_d    = 4'd1;
                    start_d    = ~start_q;
                    clear_d    = 1'b0;
                    state_d    = ST_COLLECT;
                end
            end

            ST_COLLECT: begin
                // Timeout outranks every key, so a digit arriving with it is lost.
                if (timedOut || isStar || isPound) begin
                    if (timedOut) begin
                        bad_d = 1'b1;
                    end else if (isPound) begin
                        ok_d  = fullMatch;
                        bad_d = !fullMatch;
                    end
                    clear_d = 1'b1;
                    count_d = 4'd0;
                    state_d = ST_IDLE;
                end else if (isNum) begin
                    if (count_q < CODE_LEN_C) begin
                        mismatch_d = mismatch_q | (digit != code_digit(CODE, count_q[2:0]));
                    end else begin
                        mismatch_d = 1'b1;
                    end
                    if (count_q != 4'hF) begin
                        count_d = count_q + 4'd1;
                    end
                end
            end

            default: begin
                clear_d = 1'b1;
                count_d = 4'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= 4'd0;
            mismatch_q <= 1'b0;
            clear_q    <= 1'b1;
            start_q    <= 1'b0;
            ok_q       <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            clear_q    <= clear_d;
            start_q    <= start_d;
            ok_q       <= ok_d;
            bad_q      <= bad_d;
        end
    end

    assign timer_clear = clear_q;
    assign timer_start = start_q;
    assign busy        = (state_q == ST_COLLECT);
    assign digit_count = count_q;
    assign code_ok     = ok_q;
    assign code_bad    = bad_q;

endmodule

// File: tb/tb_zcu_dtmf_code_entry.sv
// Self-checking bench for zcu_dtmf_code_entry: directed scenarios followed by random key
// traffic, all checked against a queue-based model of an entry session.
module tb_zcu_dtmf_code_entry;
    import zcu_dtmf_pkg::*;

    localparam int TIMEOUT = 5;

    logic       clk;
    logic       rst;
    logic       digit_valid;
    logic [3:0] digit;
    ms_t        elapsed;
    logic       timer_clear;
    logic       timer_start;
    logic       busy;
    logic [3:0] digit_count;
    logic       code_ok;
    logic       code_bad;

    int testsRun;
    int testsFailed;

    // Model of the session: whether an entry is open, the keys entered so far, the
    // toggle level of the timer start, and the result pulses of the last step.
    int codeDigits[4] = '{1, 3, 3, 7};
    bit mActive;
    int mKeys[$];
    bit mStart;
    bit mOk;
    bit mBad;

    zcu_dtmf_code_entry #(
        .CODE_LEN  (4),
        .CODE      (32'h0000_7331),
        .TIMEOUT_MS(24'(TIMEOUT))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digit_valid(digit_valid),
        .digit      (digit),
        .elapsed    (elapsed),
        .timer_clear(timer_clear),
        .timer_start(timer_start),
        .busy       (busy),
        .digit_count(digit_count),
        .code_ok    (code_ok),
        .code_bad   (code_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Entered code is correct only if it has exactly the code's length and every key matches.
    function automatic bit codeMatches();
        if (mKeys.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (mKeys[i] != codeDigits[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [3:0] expectedCount();
        return (mKeys.size() > 15) ? 4'd15 : 4'(mKeys.size());
    endfunction

    task automatic modelReset();
        mActive = 1'b0;
        mKeys.delete();
        mStart = 1'b0;
        mOk    = 1'b0;
        mBad   = 1'b0;
    endtask

    task automatic modelStep(input bit valid, input logic [3:0] key, input int el);
        mOk  = 1'b0;
        mBad = 1'b0;
        if (!mActive) begin
            if (valid && key <= 4'd9) begin
                mActive = 1'b1;
                mKeys.delete();
                mKeys.push_back(int'(key));
                mStart = ~mStart;
            end
        end else if (el >= TIMEOUT) begin
            mBad    = 1'b1;
            mActive = 1'b0;
            mKeys.delete();
        end else if (valid && key == DTMF_STAR) begin
            mActive = 1'b0;
            mKeys.delete();
        end else if (valid && key == DTMF_POUND) begin
            mOk     = codeMatches();
            mBad    = !mOk;
            mActive = 1'b0;
            mKeys.delete();
        end else if (valid && key <= 4'd9) begin
            mKeys.push_back(int'(key));
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".code_ok"},     {3'b0, code_ok},     {3'b0, mOk});
        checkValue({tag, ".code_bad"},    {3'b0, code_bad},    {3'b0, mBad});
        checkValue({tag, ".busy"},        {3'b0, busy},        {3'b0, mActive});
        checkValue({tag, ".timer_clear"}, {3'b0, timer_clear}, {3'b0, !mActive});
        checkValue({tag, ".timer_start"}, {3'b0, timer_start}, {3'b0, mStart});
        checkValue({tag, ".digit_count"}, digit_count,         expectedCount());
    endtask

    // One cycle of inputs; outputs are sampled 1 ns after the edge that registers them.
    task automatic applyStimulus(input bit valid, input logic [3:0] key, input int el, input string tag);
        @(negedge clk);
        digit_valid = valid;
        digit       = key;
        elapsed     = 24'(el);
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        digit       = 4'h0;
        elapsed     = 24'd0;
        modelStep(valid, key, el);
        checkOutput(tag);
    endtask

    // Quiet cycles: pulses must have dropped and nothing else may move.
    task automatic idleCycles(input int n, input string tag);
        mOk  = 1'b0;
        mBad = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checkOutput(tag);
        end
    endtask

    task automatic pressKeys(input int keys[$], input int gap, input string tag);
        foreach (keys[i]) begin
            applyStimulus(1'b1, 4'(keys[i]), 0, tag);
            idleCycles(gap, tag);
        end
    endtask

    initial begin
        int r;
        int el;
        int gap;
        bit valid;
        logic [3:0] key;

        testsRun    = 0;
        testsFailed = 0;
        digit_valid = 1'b0;
        digit       = 4'h0;
        elapsed     = 24'd0;
        rst         = 1'b1;
        modelReset();

        #1;
        checkOutput("reset_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_release");

        // Correct code, then the common wrong/short/long variants.
        pressKeys('{1, 3, 3, 7, 11}, 10, "ok_1337");
        pressKeys('{1, 3, 4, 7, 11}, 3, "bad_1347");
        pressKeys('{1, 3, 3, 11}, 2, "bad_short");
        pressKeys('{1, 3, 3, 7, 0, 11}, 2, "bad_long");

        // Abort with star, then an ignored letter and a lone pound in idle.
        pressKeys('{1, 3, 10}, 2, "abort_star");
        pressKeys('{14, 11}, 2, "idle_ignored");

        // Letter keys during an entry must not count.
        pressKeys('{1, 12, 3, 15, 3, 7, 11}, 1, "letters_in_entry");

        // Just below the limit nothing happens; at the limit the coincident digit is lost.
        applyStimulus(1'b1, 4'd1, 0, "timeout_first");
        applyStimulus(1'b0, 4'd0, TIMEOUT - 1, "timeout_below");
        applyStimulus(1'b1, 4'd3, TIMEOUT, "timeout_hit");
        idleCycles(2, "timeout_after");

        // Saturation of the digit counter on an over-long entry.
        pressKeys('{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2, 3, 4, 5, 6, 7, 11}, 0, "saturate");
        idleCycles(1, "saturate_after");

        // Asynchronous reset in the middle of an entry, between clock edges.
        pressKeys('{1, 3}, 1, "pre_reset");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        idleCycles(1, "post_reset_idle");
        pressKeys('{1, 3, 3, 7, 11}, 2, "post_reset_ok");

        // Random traffic biased towards the real code so that both outcomes occur.
        for (int i = 0; i < 300; i++) begin
            r     = $urandom_range(0, 99);
            valid = 1'b1;
            if (r < 55) begin
                key = 4'(codeDigits[(mKeys.size() > 3) ? 3 : mKeys.size()]);
            end else if (r < 72) begin
                key = 4'($urandom_range(0, 9));
            end else if (r < 84) begin
                key = DTMF_POUND;
            end else if (r < 88) begin
                key = DTMF_STAR;
            end else if (r < 94) begin
                key = 4'($urandom_range(12, 15));
            end else begin
                valid = 1'b0;
                key   = 4'($urandom_range(0, 15));
            end
            el  = ($urandom_range(0, 24) == 0) ? int'($urandom_range(TIMEOUT, TIMEOUT + 4))
                                               : int'($urandom_range(0, TIMEOUT - 1));
            gap = int'($urandom_range(0, 2));
            applyStimulus(valid, key, el, "random");
            idleCycles(gap, "random_gap");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
